// File: rtl/apb_uart_pkg.sv
// rtl/apb_uart_pkg.sv - register map, bit indices and shared UART state type
// Shared by the APB UART top and its FIFO sub-module.
package apb_uart_pkg;

  localparam logic [4:0] ADDR_STATUS  = 5'h00;
  localparam logic [4:0] ADDR_TXDATA  = 5'h04;
  localparam logic [4:0] ADDR_RXDATA  = 5'h08;
  localparam logic [4:0] ADDR_BAUDDIV = 5'h0C;
  localparam logic [4:0] ADDR_CTRL    = 5'h10;

  localparam int ST_TX_EMPTY   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_RX_EMPTY   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_TX_BUSY    = 4;
  localparam int ST_RX_OVERRUN = 5;
  localparam int ST_FRAME_ERR  = 6;
  localparam int ST_TX_DROP    = 7;

  localparam int CTRL_TX_EN = 0;
  localparam int CTRL_RX_EN = 1;
  localparam int CTRL_IE_RX = 2;
  localparam int CTRL_IE_TX = 3;

  localparam logic [3:0] CTRL_RESET = 4'h3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - count-based synchronous FIFO, head visible on rdata_o
// Push is ignored when full and pop when empty; both may happen in one cycle.
module uart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/apb_uart_fifo.sv
// rtl/apb_uart_fifo.sv - APB3 UART with TX/RX FIFOs, baud divisor, sticky flags, irq
// Tick generator and both serial FSMs live here; 16 ticks per bit.
module apb_uart_fifo
  import apb_uart_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int DIV_RESET = 651,
  parameter int DIV_W     = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [4:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             access, wr, rd;
  logic [4:0]       reg_addr;
  logic             wr_status, wr_tx, wr_baud, wr_ctrl, rd_rx;
  logic [DIV_W-1:0] baud_q, baud_d, div_cnt_q, div_cnt_d, div_max;
  logic             tick;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             ovr_q, ovr_d, ferr_q, ferr_d, drop_q, drop_d, irq_q, irq_d;
  logic             tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_ok, rx_bad;
  logic [7:0]       tx_head, rx_head;
  logic [CW-1:0]    tx_count, rx_count;
  logic [31:0]      rdata;

  uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [3:0]  tx_tcnt_q, tx_tcnt_d, rx_tcnt_q, rx_tcnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic        tx_q, tx_d, rx_s1_q, rx_s2_q;

  assign access    = PSEL & PENABLE;
  assign wr        = access & PWRITE;
  assign rd        = access & ~PWRITE;
  assign reg_addr  = {PADDR[4:2], 2'b00};
  assign wr_status = wr && (reg_addr == ADDR_STATUS);
  assign wr_tx     = wr && (reg_addr == ADDR_TXDATA);
  assign wr_baud   = wr && (reg_addr == ADDR_BAUDDIV);
  assign wr_ctrl   = wr && (reg_addr == ADDR_CTRL);
  assign rd_rx     = rd && (reg_addr == ADDR_RXDATA);
  assign PREADY    = access;

  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA[31:DIV_W], tx_count, rx_count};

  // A divisor of 0 behaves as 1: a tick every cycle.
  assign div_max   = (baud_q == '0) ? '0 : baud_q - DIV_W'(1);
  assign tick      = (div_cnt_q == div_max);
  assign div_cnt_d = (wr_baud || tick) ? '0 : div_cnt_q + DIV_W'(1);
  assign baud_d    = wr_baud ? PWDATA[DIV_W-1:0] : baud_q;
  assign ctrl_d    = wr_ctrl ? PWDATA[3:0] : ctrl_q;

  // Setting events win over a W1C in the same cycle so no event is lost.
  assign ovr_d  = (rx_ok & rx_full) | (ovr_q & ~(wr_status & PWDATA[ST_RX_OVERRUN]));
  assign ferr_d = rx_bad | (ferr_q & ~(wr_status & PWDATA[ST_FRAME_ERR]));
  assign drop_d = (wr_tx & tx_full) | (drop_q & ~(wr_status & PWDATA[ST_TX_DROP]));
  assign irq_d  = (ctrl_q[CTRL_IE_RX] & ~rx_empty) | (ctrl_q[CTRL_IE_TX] & tx_empty);

  uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk_i(PCLK), .rst_i(PRESET), .push_i(wr_tx), .wdata_i(PWDATA[7:0]), .pop_i(tx_pop),
    .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
  );

  uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk_i(PCLK), .rst_i(PRESET), .push_i(rx_ok), .wdata_i(rx_shift_q), .pop_i(rd_rx),
    .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      IDLE: if (ctrl_q[CTRL_TX_EN] && !tx_empty) begin
        tx_pop     = 1'b1;
        tx_shift_d = tx_head;
        tx_tcnt_d  = '0;
        tx_state_d = START;
      end
      START: if (tick) begin
        tx_tcnt_d = tx_tcnt_q + 4'd1;
        if (tx_tcnt_q == 4'd15) begin
          tx_bit_d   = '0;
          tx_state_d = DATA;
        end
      end
      DATA: if (tick) begin
        tx_tcnt_d = tx_tcnt_q + 4'd1;
        if (tx_tcnt_q == 4'd15) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = STOP;
        end
      end
      STOP: if (tick) begin
        tx_tcnt_d = tx_tcnt_q + 4'd1;
        if (tx_tcnt_q == 4'd15) tx_state_d = IDLE;
      end
      default: tx_state_d = IDLE;
    endcase
    // The pin is registered from the next state so it is glitch-free.
    tx_d = (tx_state_d == START) ? 1'b0 : (tx_state_d == DATA) ? tx_shift_d[0] : 1'b1;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_ok      = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state_q)
      IDLE: if (ctrl_q[CTRL_RX_EN] && !rx_s2_q) begin
        rx_tcnt_d  = '0;
        rx_state_d = START;
      end
      START: if (tick) begin
        rx_tcnt_d = rx_tcnt_q + 4'd1;
        // Mid-start check; restarting the count here centres later samples on tick 15.
        if (rx_tcnt_q == 4'd7) begin
          rx_tcnt_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? IDLE : DATA;
        end
      end
      DATA: if (tick) begin
        rx_tcnt_d = rx_tcnt_q + 4'd1;
        if (rx_tcnt_q == 4'd15) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
        end
      end
      STOP: if (tick) begin
        rx_tcnt_d = rx_tcnt_q + 4'd1;
        if (rx_tcnt_q == 4'd15) begin
          rx_ok      = rx_s2_q;
          rx_bad     = ~rx_s2_q;
          rx_state_d = IDLE;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (reg_addr)
      ADDR_STATUS: begin
        rdata[ST_TX_EMPTY]   = tx_empty;
        rdata[ST_TX_FULL]    = tx_full;
        rdata[ST_RX_EMPTY]   = rx_empty;
        rdata[ST_RX_FULL]    = rx_full;
        rdata[ST_TX_BUSY]    = (tx_state_q != IDLE);
        rdata[ST_RX_OVERRUN] = ovr_q;
        rdata[ST_FRAME_ERR]  = ferr_q;
        rdata[ST_TX_DROP]    = drop_q;
      end
      ADDR_RXDATA:  rdata[7:0]       = rx_empty ? 8'h00 : rx_head;
      ADDR_BAUDDIV: rdata[DIV_W-1:0] = baud_q;
      ADDR_CTRL:    rdata[3:0]       = ctrl_q;
      default:      rdata            = '0;
    endcase
  end

  assign PRDATA = rd ? rdata : 32'h0;
  assign tx     = tx_q;
  assign irq    = irq_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      baud_q     <= DIV_W'(DIV_RESET);
      div_cnt_q  <= '0;
      ctrl_q     <= CTRL_RESET;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      drop_q     <= 1'b0;
      irq_q      <= 1'b0;
      tx_state_q <= IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= IDLE;
      rx_tcnt_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      baud_q     <= baud_d;
      div_cnt_q  <= div_cnt_d;
      ctrl_q     <= ctrl_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      drop_q     <= drop_d;
      irq_q      <= irq_d;
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

endmodule

// File: tb/tb_apb_uart_fifo.sv
// tb/tb_apb_uart_fifo.sv - scoreboard bench for apb_uart_fifo
// Reads and serial frames are checked by monitors against queues filled by the stimulus.
module tb_apb_uart_fifo;
  import apb_uart_pkg::*;

  localparam int DEPTH = 8;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic [4:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PSEL = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        tx;
  logic        irq;
  logic        rx_drv = 1'b1;
  logic        loopback = 1'b0;
  logic        rx_line;

  assign rx_line = loopback ? tx : rx_drv;

  apb_uart_fifo #(.DEPTH(DEPTH), .DIV_RESET(651), .DIV_W(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY),
    .tx(tx), .rx(rx_line), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] rd_exp[$];
  string       rd_name[$];
  logic [7:0]  tx_exp[$];
  logic [7:0]  rx_model[$];
  bit          m_ovr = 0, m_fe = 0, m_drop = 0;
  int          div_model = 651;
  bit          tx_mon_en = 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected STATUS from the reference model's occupancy and sticky flags.
  function automatic logic [31:0] st_exp(int tx_n, int rx_n, bit busy);
    logic [31:0] s;
    s = '0;
    s[0] = (tx_n == 0);
    s[1] = (tx_n == DEPTH);
    s[2] = (rx_n == 0);
    s[3] = (rx_n == DEPTH);
    s[4] = busy;
    s[5] = m_ovr;
    s[6] = m_fe;
    s[7] = m_drop;
    return s;
  endfunction

  function automatic void rx_model_push(logic [7:0] b);
    if (rx_model.size() < DEPTH) rx_model.push_back(b);
    else m_ovr = 1;
  endfunction

  task automatic hold(int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic apb_write(logic [4:0] a, logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_read(logic [4:0] a, logic [31:0] exp, string name);
    rd_exp.push_back(exp);
    rd_name.push_back(name);
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic rx_read_next();
    apb_read(ADDR_RXDATA, {24'h0, rx_model.pop_front()}, "rxdata");
  endtask

  task automatic tx_send(logic [7:0] b);
    apb_write(ADDR_TXDATA, {24'h0, b});
    tx_exp.push_back(b);
    if (loopback) rx_model_push(b);
  endtask

  task automatic drive_rx(logic [7:0] b, bit stop_ok);
    int bc;
    bc = 16 * div_model;
    rx_drv = 0;
    hold(bc);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      hold(bc);
    end
    if (stop_ok) begin
      rx_drv = 1;
      hold(bc);
    end else begin
      rx_drv = 0;
      hold(bc * 3 / 4);
      rx_drv = 1;
    end
    hold(2 * bc);
  endtask

  task automatic wait_tx_done(int limit);
    int n;
    n = 0;
    while (tx_exp.size() != 0 && n < limit) begin
      @(posedge PCLK);
      n++;
    end
    #1;
    check("tx_drain_timeout", tx_exp.size(), 0);
    hold(16 * div_model);
  endtask

  always @(negedge PCLK) begin
    if (PSEL && PENABLE && !PWRITE) begin
      if (rd_exp.size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        check(rd_name.pop_front(), PRDATA, rd_exp.pop_front());
        check("pready", PREADY, 1);
      end
    end
  end

  // Serial decoder: samples the middle of each bit after a falling edge on tx.
  initial begin
    logic [7:0] b;
    logic       s0, s1;
    int         bc;
    forever begin
      @(negedge tx);
      if (tx_mon_en && !PRESET) begin
        bc = 16 * div_model;
        repeat (bc / 2) @(posedge PCLK);
        #1 s0 = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (bc) @(posedge PCLK);
          #1 b[i] = tx;
        end
        repeat (bc) @(posedge PCLK);
        #1 s1 = tx;
        check("tx_start_bit", s0, 0);
        check("tx_stop_bit", s1, 1);
        if (tx_exp.size() == 0) check("tx_frame_expected", 0, 1);
        else check("tx_byte", b, tx_exp.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic [7:0] fixed[4];
    fixed[0] = 8'hA5; fixed[1] = 8'h3C; fixed[2] = 8'hFF; fixed[3] = 8'h00;

    hold(3);
    check("reset_tx", tx, 1);
    check("reset_irq", irq, 0);
    check("reset_pready", PREADY, 0);
    check("reset_prdata", PRDATA, 0);
    PRESET = 0;
    apb_read(ADDR_STATUS, 32'h05, "reset_status");
    apb_read(ADDR_CTRL, 32'h3, "reset_ctrl");
    apb_read(ADDR_BAUDDIV, 32'd651, "reset_bauddiv");
    apb_read(5'h14, 32'h0, "unmapped_read");
    apb_write(5'h1C, 32'hFFFF_FFFF);
    apb_read(ADDR_CTRL, 32'h3, "ctrl_after_unmapped_write");
    apb_read(ADDR_TXDATA, 32'h0, "txdata_read");
    apb_write(ADDR_BAUDDIV, 32'd4);
    div_model = 4;
    apb_read(ADDR_BAUDDIV, 32'd4, "bauddiv_rw");

    // Single frame over loopback, busy visible mid-frame.
    loopback = 1;
    tx_send(8'h55);
    hold(100);
    apb_read(ADDR_STATUS, st_exp(0, 0, 1), "status_busy");
    wait_tx_done(2000);
    apb_read(ADDR_STATUS, st_exp(0, rx_model.size(), 0), "status_after_frame");
    rx_read_next();

    // Back-to-back loopback frames, fixed then random.
    for (int i = 0; i < 4; i++) tx_send(fixed[i]);
    for (int i = 0; i < 3; i++) tx_send(8'($urandom));
    wait_tx_done(8000);
    while (rx_model.size() != 0) rx_read_next();
    apb_read(ADDR_RXDATA, 32'h0, "rxdata_empty");
    apb_read(ADDR_STATUS, st_exp(0, 0, 0), "status_loop_drained");

    // TX disabled: overfill, then enable and drain into the RX FIFO.
    apb_write(ADDR_CTRL, 32'h2);
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'($urandom);
      apb_write(ADDR_TXDATA, {24'h0, b});
      if (i < DEPTH) begin
        tx_exp.push_back(b);
        rx_model_push(b);
      end else begin
        m_drop = 1;
      end
    end
    hold(200);
    check("tx_idle_disabled", tx, 1);
    apb_read(ADDR_STATUS, st_exp(DEPTH, 0, 0), "status_tx_full_drop");
    apb_write(ADDR_CTRL, 32'h3);
    wait_tx_done(DEPTH * 700 + 1000);
    apb_read(ADDR_STATUS, st_exp(0, DEPTH, 0), "status_rx_full");
    apb_write(ADDR_STATUS, 32'h80);
    m_drop = 0;
    apb_read(ADDR_STATUS, st_exp(0, DEPTH, 0), "status_drop_cleared");
    while (rx_model.size() != 0) rx_read_next();

    // Externally driven RX: glitch, framing error, overrun.
    loopback = 0;
    rx_drv = 0;
    hold(16);
    rx_drv = 1;
    hold(128);
    apb_read(ADDR_STATUS, st_exp(0, 0, 0), "status_after_glitch");
    drive_rx(8'($urandom), 0);
    m_fe = 1;
    apb_read(ADDR_STATUS, st_exp(0, 0, 0), "status_frame_err");
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'($urandom);
      drive_rx(b, 1);
      rx_model_push(b);
    end
    apb_read(ADDR_STATUS, st_exp(0, rx_model.size(), 0), "status_overrun");
    while (rx_model.size() != 0) rx_read_next();
    apb_read(ADDR_RXDATA, 32'h0, "rxdata_empty_after_overrun");
    apb_write(ADDR_STATUS, 32'h60);
    m_ovr = 0;
    m_fe = 0;
    apb_read(ADDR_STATUS, st_exp(0, 0, 0), "status_w1c_cleared");

    // Interrupt: tx-empty source with one-cycle latency, then rx source.
    apb_write(ADDR_CTRL, 32'hA);
    hold(1);
    check("irq_tx_empty", irq, 1);
    apb_write(ADDR_TXDATA, 32'h12);
    tx_exp.push_back(8'h12);
    check("irq_before_latency", irq, 1);
    hold(1);
    check("irq_fall_after_push", irq, 0);
    apb_write(ADDR_CTRL, 32'hB);
    wait_tx_done(2000);
    check("irq_rise_after_drain", irq, 1);
    apb_write(ADDR_CTRL, 32'h6);
    hold(2);
    check("irq_rx_idle", irq, 0);
    drive_rx(8'h9C, 1);
    rx_model_push(8'h9C);
    check("irq_rx_nonempty", irq, 1);
    rx_read_next();
    hold(1);
    check("irq_rx_cleared", irq, 0);

    // Reset in the middle of a frame.
    apb_write(ADDR_CTRL, 32'h3);
    tx_mon_en = 0;
    apb_write(ADDR_TXDATA, 32'h00);
    apb_write(ADDR_TXDATA, 32'h00);
    hold(200);
    check("tx_low_midframe", tx, 0);
    #2 PRESET = 1;
    #1;
    check("tx_high_on_reset", tx, 1);
    check("irq_low_on_reset", irq, 0);
    hold(2);
    PRESET = 0;
    div_model = 651;
    apb_read(ADDR_STATUS, 32'h05, "status_after_midframe_reset");
    apb_read(ADDR_BAUDDIV, 32'd651, "bauddiv_after_reset");
    hold(4);

    check("reads_all_seen", rd_exp.size(), 0);
    check("frames_all_seen", tx_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
